mmio_responder: RTL and testbench
=================================

MMIO_RESPONDER -- requirements
Module: mmio_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_1000, base of the 256-byte peripheral window (bits [7:0] of BASE_ADDR SHALL be zero).
REQ-002 Parameter GPIO_W, default 8, width of the GPIO output and input ports.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 mem_load  input  1  core is executing a load this cycle.
REQ-007 mem_store  input  1  core is executing a store this cycle.
REQ-008 addr  input  32  byte address from the ALU result.
REQ-009 wdata  input  32  store data from rs2.
REQ-010 cancel_data_memory  output  1  access targets the peripheral window; the control unit SHALL suppress data-memory write and data-memory read-back.
REQ-011 rdata  output  32  peripheral read data, combinational, same cycle.
REQ-012 gpio_in  input  GPIO_W  asynchronous external inputs.
REQ-013 gpio_out  output  GPIO_W  registered GPIO output.
REQ-014 timer_irq  output  1  level interrupt, equal to STATUS.match.

Function
REQ-015 hit = (mem_load | mem_store) & (addr[31:8] == BASE_ADDR[31:8]); cancel_data_memory SHALL equal hit, combinationally.
REQ-016 Register map (offset addr[7:0]): 0x00 GPIO_OUT rw; 0x04 GPIO_IN ro; 0x08 TIMER_CNT rw; 0x0C TIMER_CMP rw; 0x10 CTRL rw (bit0 en, bit1 autoreload); 0x14 STATUS (bit0 match, write-1-to-clear).
REQ-017 Writes SHALL occur at the clock edge ending a cycle with hit & mem_store, aligned address, and a mapped offset; the full 32-bit word is written, unused bits read as 0.
REQ-018 rdata SHALL be the addressed register when hit & mem_load & aligned & mapped, else 32'h0.
REQ-019 When addr[1:0] != 0 inside the window: cancel_data_memory = 1, writes ignored, rdata = 0.
REQ-020 Unmapped offsets (0x18-0xFC): cancel_data_memory = 1, writes ignored, rdata = 0.
REQ-021 GPIO_IN SHALL read the gpio_in value through a 2-flop synchroniser (2-cycle latency).
REQ-022 Timer: while CTRL.en = 1, TIMER_CNT increments by 1 each cycle, wrapping 32'hFFFF_FFFF -> 0.
REQ-023 Match: in a cycle where CTRL.en = 1 and TIMER_CNT == TIMER_CMP, STATUS.match SHALL set on the next edge; TIMER_CNT then becomes 0 if CTRL.autoreload = 1, else it holds its value and CTRL.en clears.
REQ-024 A software write to TIMER_CNT SHALL take priority over the increment and reload in the same cycle.
REQ-025 A software write to CTRL SHALL take priority over the hardware clear of CTRL.en in the same cycle.
REQ-026 A W1C of STATUS.match coincident with a new match SHALL leave match = 1; a set wins.
REQ-027 A write of 0 to STATUS bit0 SHALL have no effect.
REQ-028 The block SHALL create no combinational path from rdata or cancel_data_memory back to any input other than addr, mem_load, and mem_store.

Reset
REQ-029 On rst_n = 0, all registers (GPIO_OUT, TIMER_CNT, TIMER_CMP, CTRL, STATUS, synchroniser flops) SHALL clear to 0 immediately.
REQ-030 Under reset, gpio_out = 0 and timer_irq = 0; cancel_data_memory and rdata remain combinational and read 0 from cleared registers.
REQ-031 Reset asserted mid-count SHALL abandon the count; counting SHALL NOT resume after deassertion until CTRL.en is written.

Structure
REQ-032 Register offsets, CTRL/STATUS bit indices, and the window mask SHALL live in the shared package soc_pkg.
REQ-033 The timer (count, compare, reload, and match logic) SHALL be a sub-module mmio_timer; decode, GPIO, and the read mux SHALL stay in mmio_responder.

Verification
REQ-034 Store 32'hA5 to 0x1000 -> cancel_data_memory = 1 during the cycle, gpio_out = 8'hA5 after the edge; load 0x1000 -> rdata = 32'h0000_00A5.
REQ-035 Store to 0x0000_0800 -> cancel_data_memory = 0, and no peripheral register changes.
REQ-036 Write CMP = 5, CTRL = 3 -> timer_irq rises 6 cycles after the CTRL write; CNT reads 0 on the next cycle; counting continues.
REQ-037 CMP = 3, CTRL = 1 -> after the match, CNT holds 3, CTRL reads 0, and timer_irq = 1; W1C STATUS = 1 -> timer_irq = 0.
REQ-038 Store to 0x1002 and to 0x1018 -> cancel_data_memory = 1, no register changes; loads return 0.
REQ-039 Assert rst_n low with CNT = 100 and en = 1 -> all outputs 0 immediately; after release, CNT stays 0 over 10 cycles.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared register map, bit positions and decode helper for the MMIO peripheral window.
package soc_pkg;

  // Peripheral window: the upper 24 address bits select the 256-byte window.
  localparam logic [31:0] WINDOW_MASK = 32'hFFFF_FF00;

  // Register offsets within the window.
  localparam logic [7:0] OFF_GPIO_OUT  = 8'h00;
  localparam logic [7:0] OFF_GPIO_IN   = 8'h04;
  localparam logic [7:0] OFF_TIMER_CNT = 8'h08;
  localparam logic [7:0] OFF_TIMER_CMP = 8'h0C;
  localparam logic [7:0] OFF_CTRL      = 8'h10;
  localparam logic [7:0] OFF_STATUS    = 8'h14;

  // CTRL and STATUS bit positions.
  localparam int CTRL_EN_BIT         = 0;
  localparam int CTRL_AUTORELOAD_BIT = 1;
  localparam int STATUS_MATCH_BIT    = 0;

  // One-hot-free register selector produced by the offset decoder.
  typedef enum logic [2:0] {
    REG_GPIO_OUT  = 3'd0,
    REG_GPIO_IN   = 3'd1,
    REG_TIMER_CNT = 3'd2,
    REG_TIMER_CMP = 3'd3,
    REG_CTRL      = 3'd4,
    REG_STATUS    = 3'd5,
    REG_NONE      = 3'd7
  } reg_sel_e;

  // Write strobes handed from the decoder to the timer.
  typedef struct packed {
    logic cnt_we;
    logic cmp_we;
    logic ctrl_we;
    logic status_we;
  } timer_wr_t;

  // Maps a byte offset to a register; anything not exactly a register offset
  // (including misaligned offsets) decodes to REG_NONE.
  function automatic reg_sel_e decode_offset(input logic [7:0] off);
    reg_sel_e sel;
    case (off)
      OFF_GPIO_OUT:  sel = REG_GPIO_OUT;
      OFF_GPIO_IN:   sel = REG_GPIO_IN;
      OFF_TIMER_CNT: sel = REG_TIMER_CNT;
      OFF_TIMER_CMP: sel = REG_TIMER_CMP;
      OFF_CTRL:      sel = REG_CTRL;
      OFF_STATUS:    sel = REG_STATUS;
      default:       sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mmio_responder_if.sv
// Core-side load/store bus into the MMIO responder.
interface mmio_responder_if;

  logic        mem_load;
  logic        mem_store;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        cancel_data_memory;
  logic [31:0] rdata;

  // The core drives the access and consumes the cancel/read-back.
  modport master (
    output mem_load,
    output mem_store,
    output addr,
    output wdata,
    input  cancel_data_memory,
    input  rdata
  );

  // The responder observes the access and answers combinationally.
  modport slave (
    input  mem_load,
    input  mem_store,
    input  addr,
    input  wdata,
    output cancel_data_memory,
    output rdata
  );

endinterface

// File: rtl/mmio_timer.sv
// 32-bit free-running timer with compare match, optional autoreload and a
// sticky write-1-to-clear match flag.
module mmio_timer
  import soc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  timer_wr_t   wr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] cnt_o,
  output logic [31:0] cmp_o,
  output logic        ctrl_en_o,
  output logic        ctrl_autoreload_o,
  output logic        match_o
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        autoreload_q, autoreload_d;
  logic        match_q, match_d;
  logic        match_now;

  // A match is only recognised while the timer is enabled.
  assign match_now = en_q && (cnt_q == cmp_q);

  // Next-state logic: software writes beat hardware updates, a new match beats a W1C.
  always_comb begin
    cnt_d        = cnt_q;
    cmp_d        = cmp_q;
    en_d         = en_q;
    autoreload_d = autoreload_q;
    match_d      = match_q;

    if (wr_i.cnt_we) begin
      cnt_d = wdata_i;
    end else if (match_now) begin
      cnt_d = autoreload_q ? 32'h0 : cnt_q;
    end else if (en_q) begin
      cnt_d = cnt_q + 32'd1;
    end

    if (wr_i.cmp_we) begin
      cmp_d = wdata_i;
    end

    if (wr_i.ctrl_we) begin
      en_d         = wdata_i[CTRL_EN_BIT];
      autoreload_d = wdata_i[CTRL_AUTORELOAD_BIT];
    end else if (match_now && !autoreload_q) begin
      en_d = 1'b0;
    end

    if (match_now) begin
      match_d = 1'b1;
    end else if (wr_i.status_we && wdata_i[STATUS_MATCH_BIT]) begin
      match_d = 1'b0;
    end
  end

  // Timer state registers, cleared asynchronously so a reset abandons any count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= 32'h0;
      cmp_q        <= 32'h0;
      en_q         <= 1'b0;
      autoreload_q <= 1'b0;
      match_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      cmp_q        <= cmp_d;
      en_q         <= en_d;
      autoreload_q <= autoreload_d;
      match_q      <= match_d;
    end
  end

  assign cnt_o             = cnt_q;
  assign cmp_o             = cmp_q;
  assign ctrl_en_o         = en_q;
  assign ctrl_autoreload_o = autoreload_q;
  assign match_o           = match_q;

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped peripheral responder: window decode, GPIO registers, timer
// instance and the combinational read-back mux.
module mmio_responder
  import soc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mmio_responder_if.slave   bus,
  input  logic [GPIO_W-1:0] gpio_in_i,
  output logic [GPIO_W-1:0] gpio_out_o,
  output logic              timer_irq_o
);

  logic              hit;
  logic              aligned;
  logic              mapped;
  logic              wr_en;
  logic              rd_en;
  reg_sel_e          sel;
  timer_wr_t         timer_wr;

  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] sync1_q;
  logic [GPIO_W-1:0] sync2_q;

  logic [31:0]       timer_cnt;
  logic [31:0]       timer_cmp;
  logic              timer_en;
  logic              timer_autoreload;
  logic              timer_match;
  logic [31:0]       rd_mux;

  // Address decode: depends only on addr and the load/store strobes, so the
  // cancel output never loops back through register state.
  always_comb begin
    hit     = (bus.mem_load | bus.mem_store) &&
              ((bus.addr & WINDOW_MASK) == (BASE_ADDR & WINDOW_MASK));
    aligned = (bus.addr[1:0] == 2'b00);
    sel     = decode_offset(bus.addr[7:0]);
    mapped  = (sel != REG_NONE);
    wr_en   = hit && bus.mem_store && aligned && mapped;
    rd_en   = hit && bus.mem_load && aligned && mapped;
  end

  assign bus.cancel_data_memory = hit;

  // Per-register write strobes toward the timer; GPIO_IN is read-only.
  always_comb begin
    timer_wr           = '0;
    timer_wr.cnt_we    = wr_en && (sel == REG_TIMER_CNT);
    timer_wr.cmp_we    = wr_en && (sel == REG_TIMER_CMP);
    timer_wr.ctrl_we   = wr_en && (sel == REG_CTRL);
    timer_wr.status_we = wr_en && (sel == REG_STATUS);
  end

  // GPIO output next state: load the low GPIO_W bits of the store data.
  always_comb begin
    gpio_out_d = gpio_out_q;
    if (wr_en && (sel == REG_GPIO_OUT)) begin
      gpio_out_d = bus.wdata[GPIO_W-1:0];
    end
  end

  // GPIO output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out_q <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
    end
  end

  // Two-flop synchroniser for the asynchronous GPIO inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_in_i;
      sync2_q <= sync1_q;
    end
  end

  mmio_timer u_timer (
    .clk               (clk),
    .rst_n             (rst_n),
    .wr_i              (timer_wr),
    .wdata_i           (bus.wdata),
    .cnt_o             (timer_cnt),
    .cmp_o             (timer_cmp),
    .ctrl_en_o         (timer_en),
    .ctrl_autoreload_o (timer_autoreload),
    .match_o           (timer_match)
  );

  // Read-back mux: zero unless a valid aligned load hits a mapped register.
  always_comb begin
    rd_mux = 32'h0;
    if (rd_en) begin
      case (sel)
        REG_GPIO_OUT:  rd_mux[GPIO_W-1:0] = gpio_out_q;
        REG_GPIO_IN:   rd_mux[GPIO_W-1:0] = sync2_q;
        REG_TIMER_CNT: rd_mux = timer_cnt;
        REG_TIMER_CMP: rd_mux = timer_cmp;
        REG_CTRL: begin
          rd_mux[CTRL_EN_BIT]         = timer_en;
          rd_mux[CTRL_AUTORELOAD_BIT] = timer_autoreload;
        end
        REG_STATUS:    rd_mux[STATUS_MATCH_BIT] = timer_match;
        default:       rd_mux = 32'h0;
      endcase
    end
  end

  assign bus.rdata   = rd_mux;
  assign gpio_out_o  = gpio_out_q;
  assign timer_irq_o = timer_match;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed, table-driven bench for mmio_responder plus hand sequences for the
// timer, synchroniser and reset corner cases.
module tb_mmio_responder;

  localparam logic [31:0] A_GPIO_OUT = 32'h0000_1000;
  localparam logic [31:0] A_GPIO_IN  = 32'h0000_1004;
  localparam logic [31:0] A_CNT      = 32'h0000_1008;
  localparam logic [31:0] A_CMP      = 32'h0000_100C;
  localparam logic [31:0] A_CTRL     = 32'h0000_1010;
  localparam logic [31:0] A_STATUS   = 32'h0000_1014;
  localparam int          NVEC       = 26;

  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expCancel;
    logic [31:0] expRdata;
    logic [7:0]  expGpio;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic       timer_irq;

  int errors;
  int checks;

  vec_t vecs [NVEC];

  mmio_responder_if bus ();

  mmio_responder #(
    .BASE_ADDR (32'h0000_1000),
    .GPIO_W    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .gpio_in_i   (gpio_in),
    .gpio_out_o  (gpio_out),
    .timer_irq_o (timer_irq)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one bus request onto the interface.
  task automatic applyStimulus(input logic ld, input logic st,
                               input logic [31:0] a, input logic [31:0] wd);
    bus.mem_load  = ld;
    bus.mem_store = st;
    bus.addr      = a;
    bus.wdata     = wd;
  endtask

  // Compares one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Advances to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle store, then return the bus to idle.
  task automatic doWrite(input logic [31:0] a, input logic [31:0] wd);
    applyStimulus(1'b0, 1'b1, a, wd);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // One-cycle load with a same-cycle read-data check.
  task automatic doRead(input string name, input logic [31:0] a,
                        input logic [31:0] expected);
    applyStimulus(1'b1, 1'b0, a, 32'h0);
    #1;
    checkOutput(name, bus.rdata, expected);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    errors = 0;
    checks = 0;

    //            ld    st    addr          wdata         cancel rdata         gpio
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_00A5, 1'b1, 32'h0,        8'hA5};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0000_00A5, 8'hA5};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0800, 32'h0000_00FF, 1'b0, 32'h0,        8'hA5};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0000_00A5, 8'hA5};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_1002, 32'h0000_003C, 1'b1, 32'h0,        8'hA5};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_1002, 32'h0,         1'b1, 32'h0,        8'hA5};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0000_00A5, 8'hA5};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_1018, 32'h0000_0077, 1'b1, 32'h0,        8'hA5};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_1018, 32'h0,         1'b1, 32'h0,        8'hA5};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_100C, 32'h1234_5678, 1'b1, 32'h0,        8'hA5};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_100C, 32'h0,         1'b1, 32'h1234_5678, 8'hA5};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_080C, 32'hDEAD_BEEF, 1'b0, 32'h0,        8'hA5};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_100E, 32'h0,         1'b1, 32'h0,        8'hA5};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_100C, 32'h0,         1'b1, 32'h1234_5678, 8'hA5};
    vecs[14] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,         1'b0, 32'h0,        8'hA5};
    vecs[15] = '{1'b1, 1'b0, 32'h0001_1000, 32'h0,         1'b0, 32'h0,        8'hA5};
    vecs[16] = '{1'b0, 1'b1, 32'h0000_1004, 32'h0,         1'b1, 32'h0,        8'hA5};
    vecs[17] = '{1'b1, 1'b0, 32'h0000_1004, 32'h0,         1'b1, 32'h0000_005A, 8'hA5};
    vecs[18] = '{1'b0, 1'b1, 32'h0000_1000, 32'hFFFF_FF3C, 1'b1, 32'h0,        8'h3C};
    vecs[19] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0000_003C, 8'h3C};
    vecs[20] = '{1'b1, 1'b0, 32'h0000_1010, 32'h0,         1'b1, 32'h0,        8'h3C};
    vecs[21] = '{1'b1, 1'b0, 32'h0000_10FC, 32'h0,         1'b1, 32'h0,        8'h3C};
    vecs[22] = '{1'b0, 1'b1, 32'h0000_100C, 32'h0,         1'b1, 32'h0,        8'h3C};
    vecs[23] = '{1'b1, 1'b0, 32'h0000_100C, 32'h0,         1'b1, 32'h0,        8'h3C};
    vecs[24] = '{1'b1, 1'b0, 32'h0000_1008, 32'h0,         1'b1, 32'h0,        8'h3C};
    vecs[25] = '{1'b1, 1'b0, 32'h0000_1014, 32'h0,         1'b1, 32'h0,        8'h3C};

    // Reset state, including combinational read-back while held in reset.
    rst_n   = 1'b0;
    gpio_in = 8'h5A;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_gpio_out", {24'h0, gpio_out}, 32'h0);
    checkOutput("reset_irq", {31'h0, timer_irq}, 32'h0);
    applyStimulus(1'b1, 1'b0, A_CNT, 32'h0);
    #1;
    checkOutput("reset_cancel", {31'h0, bus.cancel_data_memory}, 32'h1);
    checkOutput("reset_cnt_read", bus.rdata, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table of single-cycle bus accesses.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].ld, vecs[i].st, vecs[i].addr, vecs[i].wdata);
      #1;
      checkOutput($sformatf("vec%0d_cancel", i), {31'h0, bus.cancel_data_memory},
                  {31'h0, vecs[i].expCancel});
      checkOutput($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].expRdata);
      step();
      checkOutput($sformatf("vec%0d_gpio", i), {24'h0, gpio_out}, {24'h0, vecs[i].expGpio});
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    end

    // Synchroniser latency: new input visible after exactly two edges.
    gpio_in = 8'hC3;
    applyStimulus(1'b1, 1'b0, A_GPIO_IN, 32'h0);
    #1;
    checkOutput("sync_edge0", bus.rdata, 32'h0000_005A);
    step();
    checkOutput("sync_edge1", bus.rdata, 32'h0000_005A);
    step();
    checkOutput("sync_edge2", bus.rdata, 32'h0000_00C3);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

    // Autoreload: CMP=5, CTRL=3, match flag rises six edges after the CTRL write.
    doWrite(A_CMP, 32'd5);
    doWrite(A_CNT, 32'd0);
    doWrite(A_CTRL, 32'd3);
    for (int k = 1; k <= 6; k++) begin
      step();
      checkOutput($sformatf("ar_irq_edge%0d", k), {31'h0, timer_irq},
                  (k == 6) ? 32'h1 : 32'h0);
    end
    doRead("ar_cnt_reload", A_CNT, 32'd0);
    doRead("ar_cnt_continue", A_CNT, 32'd1);
    doRead("ar_status", A_STATUS, 32'h1);

    // CNT write beats increment; coincident W1C and match leaves match set.
    doWrite(A_CNT, 32'd5);
    doWrite(A_STATUS, 32'h1);
    checkOutput("w1c_vs_match_irq", {31'h0, timer_irq}, 32'h1);
    doWrite(A_STATUS, 32'h0);
    checkOutput("w1c_zero_irq", {31'h0, timer_irq}, 32'h1);
    doWrite(A_STATUS, 32'h1);
    checkOutput("w1c_clear_irq", {31'h0, timer_irq}, 32'h0);
    doRead("ar_cnt_after_w1c", A_CNT, 32'd2);
    doWrite(A_CTRL, 32'd0);
    doRead("stop_cnt", A_CNT, 32'd4);

    // One-shot: CMP=3, CTRL=1, count holds and enable clears on match.
    doWrite(A_CMP, 32'd3);
    doWrite(A_CNT, 32'd0);
    doWrite(A_CTRL, 32'd1);
    repeat (6) step();
    checkOutput("oneshot_irq", {31'h0, timer_irq}, 32'h1);
    doRead("oneshot_cnt", A_CNT, 32'd3);
    doRead("oneshot_ctrl", A_CTRL, 32'h0);
    doWrite(A_STATUS, 32'h1);
    checkOutput("oneshot_irq_clr", {31'h0, timer_irq}, 32'h0);
    doRead("oneshot_status", A_STATUS, 32'h0);

    // CTRL write beats the hardware clear of en on a one-shot match.
    doWrite(A_CTRL, 32'd1);
    doWrite(A_CTRL, 32'd1);
    doRead("ctrl_prio_en", A_CTRL, 32'h1);
    checkOutput("ctrl_prio_irq", {31'h0, timer_irq}, 32'h1);
    doRead("ctrl_prio_cleared", A_CTRL, 32'h0);
    doWrite(A_STATUS, 32'h1);

    // Reset mid-count with irq and gpio active.
    doWrite(A_CMP, 32'd102);
    doWrite(A_CNT, 32'd100);
    doWrite(A_CTRL, 32'd3);
    repeat (3) step();
    checkOutput("prereset_irq", {31'h0, timer_irq}, 32'h1);
    doWrite(A_CNT, 32'd100);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_gpio", {24'h0, gpio_out}, 32'h0);
    checkOutput("midreset_irq", {31'h0, timer_irq}, 32'h0);
    applyStimulus(1'b1, 1'b0, A_CNT, 32'h0);
    #1;
    checkOutput("midreset_cnt", bus.rdata, 32'h0);
    applyStimulus(1'b1, 1'b0, A_CTRL, 32'h0);
    #1;
    checkOutput("midreset_ctrl", bus.rdata, 32'h0);
    applyStimulus(1'b1, 1'b0, A_GPIO_OUT, 32'h0);
    #1;
    checkOutput("midreset_gpio_read", bus.rdata, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 10; k++) begin
      doRead($sformatf("postreset_cnt%0d", k), A_CNT, 32'h0);
    end
    checkOutput("postreset_irq", {31'h0, timer_irq}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
